// File: rtl/fmul_chk_pkg.sv
// rtl/fmul_chk_pkg.sv - shared types, FP32 field constants and NaN helper for the result checker
package fmul_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_e;

    localparam int EXP_MSB = 30;
    localparam int EXP_LSB = 23;
    localparam int MANT_W  = 23;

    // FP32 NaN: all-ones exponent with a non-zero mantissa (infinity is not a NaN).
    function automatic logic is_nan(input logic [31:0] w);
        return (&w[EXP_MSB:EXP_LSB]) && (w[MANT_W-1:0] != '0);
    endfunction

endpackage

// File: rtl/chk_sync_fifo.sv
// rtl/chk_sync_fifo.sv - synchronous FIFO holding golden words for the result checker
// Ports: clk/reset (async active-high), clr (sync flush), push_i/push_data_i,
//        pop_i, head_o (word at read pointer), full_o, empty_o.
module chk_sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the index bits match.
    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/fmul_result_checker.sv
// rtl/fmul_result_checker.sv - FP32 result scoreboard comparing DUT results against queued golden words
// Ports: clk, reset (async active-high), start/stop control pulses,
//        exp_valid/exp_data/exp_ready golden-word stream, res_valid/res_data DUT results,
//        mismatch pulse, pass/fail counters, first-failure capture, sticky ordering flags, done.
import fmul_chk_pkg::*;

module fmul_result_checker #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 32,
    parameter int NAN_EQ    = 1,
    parameter int DRAIN_TMO = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              exp_valid,
    input  logic [DATA_W-1:0] exp_data,
    output logic              exp_ready,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              mismatch,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  first_fail_idx,
    output logic [DATA_W-1:0] first_fail_exp,
    output logic [DATA_W-1:0] first_fail_got,
    output logic              underflow,
    output logic              overflow,
    output logic              lost,
    output logic              done
);
    localparam int TMO_W = $clog2(DRAIN_TMO) + 1;

    chk_state_e        state_q, state_d;
    logic              full, empty, active, push, pop, hit, tmo_hit;
    logic [DATA_W-1:0] head;
    logic [TMO_W-1:0]  tmo_q;
    logic [CNT_W-1:0]  pass_q, fail_q, idx_q, ff_idx_q;
    logic [DATA_W-1:0] ff_exp_q, ff_got_q;
    logic              mismatch_q, underflow_q, overflow_q, lost_q;

    assign active    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign exp_ready = (state_q == ST_RUN) && !full;
    // start flushes everything, so traffic in that same cycle is discarded.
    assign push      = exp_valid && exp_ready && !start;
    assign pop       = active && res_valid && !empty && !start;
    assign hit       = (head == res_data) ||
                       ((NAN_EQ != 0) && is_nan(head) && is_nan(res_data));
    // Last idle DRAIN cycle with words still queued: give up and report them lost.
    assign tmo_hit   = (state_q == ST_DRAIN) && (tmo_q == TMO_W'(DRAIN_TMO - 1)) &&
                       !res_valid && !empty;

    chk_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (start),
        .push_i      (push),
        .push_data_i (exp_data),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty)
    );

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:   if (stop) state_d = ST_DRAIN;
                ST_DRAIN: if (empty || tmo_hit) state_d = ST_DONE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset || start) begin
            mismatch_q  <= 1'b0;
            pass_q      <= '0;
            fail_q      <= '0;
            idx_q       <= '0;
            ff_idx_q    <= '0;
            ff_exp_q    <= '0;
            ff_got_q    <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            lost_q      <= 1'b0;
            tmo_q       <= '0;
        end else begin
            mismatch_q <= 1'b0;
            if (pop) begin
                if (~&idx_q) idx_q <= idx_q + 1'b1;
                if (hit) begin
                    if (~&pass_q) pass_q <= pass_q + 1'b1;
                end else begin
                    mismatch_q <= 1'b1;
                    if (~&fail_q) fail_q <= fail_q + 1'b1;
                    if (fail_q == '0) begin
                        ff_idx_q <= idx_q;
                        ff_exp_q <= head;
                        ff_got_q <= res_data;
                    end
                end
            end
            // A result arriving with nothing queued (including a same-cycle push) is dropped.
            if (active && res_valid && empty) underflow_q <= 1'b1;
            if ((state_q == ST_RUN) && exp_valid && !exp_ready) overflow_q <= 1'b1;
            if (tmo_hit) lost_q <= 1'b1;
            if (state_q == ST_DRAIN) begin
                if (res_valid) tmo_q <= '0;
                else           tmo_q <= tmo_q + 1'b1;
            end else begin
                tmo_q <= '0;
            end
        end
    end

    assign mismatch       = mismatch_q;
    assign pass_cnt       = pass_q;
    assign fail_cnt       = fail_q;
    assign first_fail_idx = ff_idx_q;
    assign first_fail_exp = ff_exp_q;
    assign first_fail_got = ff_got_q;
    assign underflow      = underflow_q;
    assign overflow       = overflow_q;
    assign lost           = lost_q;
    assign done           = (state_q == ST_DONE);
    assign err_sticky     = (fail_q != '0) || underflow_q || overflow_q || lost_q;

endmodule

// File: tb/tb_fmul_result_checker.sv
// tb/tb_fmul_result_checker.sv - self-checking bench for fmul_result_checker
module tb_fmul_result_checker;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 16;
    localparam int CNT_W     = 32;
    localparam int DRAIN_TMO = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0, stop = 1'b0;
    logic              exp_valid = 1'b0, res_valid = 1'b0;
    logic [DATA_W-1:0] exp_data = '0, res_data = '0;
    logic              exp_ready, mismatch, err_sticky, underflow, overflow, lost, done;
    logic [CNT_W-1:0]  pass_cnt, fail_cnt, first_fail_idx;
    logic [DATA_W-1:0] first_fail_exp, first_fail_got;

    fmul_result_checker #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .NAN_EQ(1), .DRAIN_TMO(DRAIN_TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
        .res_valid(res_valid), .res_data(res_data),
        .mismatch(mismatch), .err_sticky(err_sticky),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail_idx(first_fail_idx), .first_fail_exp(first_fail_exp),
        .first_fail_got(first_fail_got),
        .underflow(underflow), .overflow(overflow), .lost(lost), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] e;
        logic [31:0] g;
        bit          p;
    } vec_t;

    vec_t        vecs[7];
    logic [31:0] model_q[$];
    bit          sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          mpass = 0;
    int          mfail = 0;

    function automatic bit ref_nan(input logic [31:0] w);
        return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
    endfunction

    function automatic bit ref_mis(input logic [31:0] e, input logic [31:0] g);
        return !((e == g) || (ref_nan(e) && ref_nan(g)));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        model_q.delete();
        sb_q.delete();
        mpass = 0;
        mfail = 0;
    endtask

    task automatic push_w(input logic [31:0] w);
        exp_valid = 1'b1;
        exp_data  = w;
        if (exp_ready) model_q.push_back(w);
        step();
        exp_valid = 1'b0;
    endtask

    // Drives one result; expectation is queued when driven and checked when the DUT reports.
    task automatic send_res(input logic [31:0] g, input bit exp_mis);
        logic [31:0] e;
        res_valid = 1'b1;
        res_data  = g;
        if (model_q.size() > 0) begin
            e = model_q.pop_front();
            sb_q.push_back(exp_mis);
            if (exp_mis) mfail++;
            else         mpass++;
        end
        step();
        res_valid = 1'b0;
        if (sb_q.size() > 0) chk("mismatch", 64'(mismatch), 64'(sb_q.pop_front()));
        chk("pass_cnt", 64'(pass_cnt), 64'(mpass));
        chk("fail_cnt", 64'(fail_cnt), 64'(mfail));
    endtask

    initial begin
        int n;
        vecs[0] = '{32'h3F800000, 32'h3F800000, 1'b1};
        vecs[1] = '{32'h40000000, 32'h40000000, 1'b1};
        vecs[2] = '{32'h40400000, 32'h40400001, 1'b0};
        vecs[3] = '{32'h7FC00000, 32'h7F800001, 1'b1};
        vecs[4] = '{32'h7F800000, 32'h7FC00000, 1'b0};
        vecs[5] = '{32'hFFC00000, 32'h7FC00001, 1'b1};
        vecs[6] = '{32'h00000000, 32'h80000000, 1'b0};

        repeat (3) step();
        chk("rst_pass", 64'(pass_cnt), 0);
        chk("rst_err", 64'(err_sticky), 0);
        chk("rst_ready", 64'(exp_ready), 0);
        chk("rst_done", 64'(done), 0);
        reset = 1'b0;
        step();

        // stop in IDLE is ignored; start+stop together enters RUN
        stop = 1'b1; step(); stop = 1'b0;
        chk("idle_stop_ready", 64'(exp_ready), 0);
        chk("idle_stop_done", 64'(done), 0);
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        chk("start_wins_ready", 64'(exp_ready), 1);

        // table vectors, results back to back
        do_start();
        for (int i = 0; i < 7; i++) push_w(vecs[i].e);
        for (int i = 0; i < 7; i++) begin
            send_res(vecs[i].g, !vecs[i].p);
            if (i == 0) chk("no_mis_0", 64'(mismatch), 0);
        end
        step();
        chk("mis_clears", 64'(mismatch), 0);
        chk("ff_idx", 64'(first_fail_idx), 2);
        chk("ff_exp", 64'(first_fail_exp), 64'h40400000);
        chk("ff_got", 64'(first_fail_got), 64'h40400001);
        chk("tbl_err", 64'(err_sticky), 1);

        // underflow on empty FIFO
        do_start();
        chk("start_clears_fail", 64'(fail_cnt), 0);
        res_valid = 1'b1; res_data = 32'h3F800000; step(); res_valid = 1'b0;
        chk("uf_flag", 64'(underflow), 1);
        chk("uf_err", 64'(err_sticky), 1);
        chk("uf_pass", 64'(pass_cnt), 0);
        chk("uf_fail", 64'(fail_cnt), 0);

        // same-cycle push into empty FIFO plus result: result dropped, word kept
        do_start();
        exp_valid = 1'b1; exp_data = 32'h41200000;
        res_valid = 1'b1; res_data = 32'h41200000;
        model_q.push_back(32'h41200000);
        step();
        exp_valid = 1'b0; res_valid = 1'b0;
        chk("sc_uf", 64'(underflow), 1);
        chk("sc_pass0", 64'(pass_cnt), 0);
        send_res(32'h41200000, ref_mis(32'h41200000, 32'h41200000));

        // fill to DEPTH, then overflow, then full+push+pop
        do_start();
        for (int i = 0; i < DEPTH; i++) push_w(32'h3F000000 + 32'(i));
        chk("full_ready", 64'(exp_ready), 0);
        chk("full_no_ovf", 64'(overflow), 0);
        exp_valid = 1'b1; exp_data = 32'hDEADBEEF; step();
        chk("ovf_flag", 64'(overflow), 1);
        send_res(32'h3F000000, ref_mis(model_q[0], 32'h3F000000));
        exp_valid = 1'b0;
        chk("after_pop_ready", 64'(exp_ready), 1);
        send_res(32'h3F000001, ref_mis(model_q[0], 32'h3F000001));

        // DRAIN timeout with entries left
        do_start();
        push_w(32'h40800000);
        push_w(32'h40A00000);
        stop = 1'b1; step(); stop = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            step();
            n++;
        end
        chk("drain_cycles", 64'(n), 64'(DRAIN_TMO));
        chk("lost_flag", 64'(lost), 1);
        chk("lost_err", 64'(err_sticky), 1);
        res_valid = 1'b1; res_data = 32'h40800000; step(); res_valid = 1'b0;
        chk("done_ignore_pass", 64'(pass_cnt), 0);
        chk("done_ignore_uf", 64'(underflow), 0);

        // normal drain empties and finishes without lost
        do_start();
        push_w(32'h40C00000);
        stop = 1'b1; step(); stop = 1'b0;
        send_res(32'h40C00000, ref_mis(32'h40C00000, 32'h40C00000));
        n = 0;
        while (!done && n < 10) begin
            step();
            n++;
        end
        chk("drain_done", 64'(done), 1);
        chk("drain_no_lost", 64'(lost), 0);

        // async reset mid-RUN
        do_start();
        push_w(32'h41000000);
        send_res(32'h41000001, ref_mis(32'h41000000, 32'h41000001));
        #2 reset = 1'b1;
        #1;
        chk("arst_fail", 64'(fail_cnt), 0);
        chk("arst_err", 64'(err_sticky), 0);
        chk("arst_ffexp", 64'(first_fail_exp), 0);
        chk("arst_ready", 64'(exp_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("idle_after_rst", 64'(exp_ready), 0);
        chk("idle_done", 64'(done), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
